// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// Latency: n/a (types, constants and a pure classification function only).
// Backpressure: n/a.
package trace_pkg;

    localparam int INUM_W = 32;
    localparam int DROP_W = 16;
    localparam int CYC_W  = 32;
    localparam int KIND_W = 3;

    typedef enum logic [KIND_W-1:0] {
        KIND_NOP_BR = 3'd0,
        KIND_REG    = 3'd1,
        KIND_LD     = 3'd2,
        KIND_ST     = 3'd3,
        KIND_STU    = 3'd4
    } trace_kind_e;

    // A store that also writes a register (e.g. store-conditional) wins over
    // a load; a load without a register write is not a useful trace event.
    function automatic trace_kind_e classify_kind(input logic reg_write,
                                                  input logic mem_read,
                                                  input logic mem_write);
        trace_kind_e k;
        k = KIND_NOP_BR;
        if (reg_write && mem_write) begin
            k = KIND_STU;
        end else if (reg_write && mem_read) begin
            k = KIND_LD;
        end else if (reg_write) begin
            k = KIND_REG;
        end else if (mem_write) begin
            k = KIND_ST;
        end
        return k;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO holding WIDTH-bit words in DEPTH slots.
// Latency: a pushed word is visible at dout_o one cycle later; no bypass.
// Backpressure: push when full is accepted only together with a pop; pop when empty is ignored.
module trace_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && ((level_q != LVL_W'(DEPTH)) || do_pop);

    // Occupancy changes only when exactly one of push/pop happens.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Storage; when full with push+pop the write lands in the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into packed trace records and queues them for a drain port
// (TRACE_CYCLE_STAMP_EN prepends a 32-bit cycle stamp). Latency: 1 cycle from retirement to tr_valid.
// Backpressure: tr_valid/tr_ready drain; when full without a pop the retirement is dropped and counted.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int  XLEN          = 32,
    parameter int  RA_W          = 5,
    parameter int  DEPTH         = 16,
    parameter int  STALL_ON_FULL = 0,
    localparam int LVL_W         = $clog2(DEPTH + 1),
`ifdef TRACE_CYCLE_STAMP_EN
    localparam int STAMP_W       = CYC_W,
`else
    localparam int STAMP_W       = 0,
`endif
    localparam int BASE_W        = INUM_W + KIND_W + XLEN + 32 + RA_W + 3 * XLEN,
    localparam int TR_W          = STAMP_W + BASE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ret_valid,
    input  logic [XLEN-1:0]   ret_pc,
    input  logic [31:0]       ret_instr,
    input  logic              ret_reg_write,
    input  logic [RA_W-1:0]   ret_rd,
    input  logic [XLEN-1:0]   ret_wdata,
    input  logic              ret_mem_read,
    input  logic              ret_mem_write,
    input  logic [XLEN-1:0]   ret_mem_addr,
    input  logic [XLEN-1:0]   ret_mem_data,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [TR_W-1:0]   tr_record,
    output logic              stall_req,
    output logic [LVL_W-1:0]  level,
    output logic [INUM_W-1:0] inst_count,
    output logic [DROP_W-1:0] drop_count
);

    logic [INUM_W-1:0] inst_count_q, inst_count_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic [LVL_W-1:0]  fifo_level;
    logic [BASE_W-1:0] rec_base;
    logic [TR_W-1:0]   rec_in, fifo_dout;
    logic              counted, do_pop, do_push, do_drop, full;
    trace_kind_e       kind;

    assign kind     = classify_kind(ret_reg_write, ret_mem_read, ret_mem_write);
    assign rec_base = {inst_count_q, KIND_W'(kind), ret_pc, ret_instr, ret_rd,
                       ret_wdata, ret_mem_addr, ret_mem_data};

`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    assign cyc_d  = cyc_q + CYC_W'(1);
    assign rec_in = {cyc_q, rec_base};

    // Free-running cycle stamp, zero in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end
`else
    assign rec_in = rec_base;
`endif

    assign full     = (fifo_level == LVL_W'(DEPTH));
    assign tr_valid = (fifo_level != '0);
    assign do_pop   = tr_valid && tr_ready;
    assign counted  = ret_valid && enable;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_push  = counted && (!full || do_pop);
    assign do_drop  = counted && full && !do_pop;

    // Every counted retirement consumes an inum, dropped or not, so drops show up as gaps.
    always_comb begin
        inst_count_d = inst_count_q;
        drop_count_d = drop_count_q;
        if (counted) inst_count_d = inst_count_q + INUM_W'(1);
        if (do_drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_W'(1);
    end

    // Counter registers; reset wins over any retirement in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            inst_count_q <= inst_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    trace_fifo #(
        .WIDTH (TR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .din_i   (rec_in),
        .dout_o  (fifo_dout),
        .level_o (fifo_level)
    );

    // Hide stale storage so an empty buffer presents an all-zero record.
    assign tr_record  = tr_valid ? fifo_dout : '0;
    assign stall_req  = (STALL_ON_FULL != 0) && full;
    assign level      = fifo_level;
    assign inst_count = inst_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    localparam int DEPTH  = 4;
    localparam int BASE_W = 32 + 3 + 32 + 32 + 5 + 3 * 32;
`ifdef TRACE_CYCLE_STAMP_EN
    localparam int TR_W   = 32 + BASE_W;
`else
    localparam int TR_W   = BASE_W;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            ret_valid = 1'b0;
    logic [31:0]     ret_pc = '0, ret_instr = '0, ret_wdata = '0;
    logic [31:0]     ret_mem_addr = '0, ret_mem_data = '0;
    logic            ret_reg_write = 1'b0, ret_mem_read = 1'b0, ret_mem_write = 1'b0;
    logic [4:0]      ret_rd = '0;
    logic            tr_ready = 1'b0;

    logic            tr_valid0, tr_valid1, stall0, stall1;
    logic [TR_W-1:0] tr_record0, tr_record1;
    logic [2:0]      level0, level1;
    logic [31:0]     icnt0, icnt1;
    logic [15:0]     drop0, drop1;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(32), .RA_W(5), .DEPTH(DEPTH), .STALL_ON_FULL(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ret_valid(ret_valid),
        .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_reg_write(ret_reg_write),
        .ret_rd(ret_rd), .ret_wdata(ret_wdata), .ret_mem_read(ret_mem_read),
        .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
        .tr_valid(tr_valid0), .tr_ready(tr_ready), .tr_record(tr_record0),
        .stall_req(stall0), .level(level0), .inst_count(icnt0), .drop_count(drop0)
    );

    commit_trace_buffer #(.XLEN(32), .RA_W(5), .DEPTH(DEPTH), .STALL_ON_FULL(1)) dut_stall (
        .clk(clk), .rst(rst), .enable(enable), .ret_valid(ret_valid),
        .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_reg_write(ret_reg_write),
        .ret_rd(ret_rd), .ret_wdata(ret_wdata), .ret_mem_read(ret_mem_read),
        .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
        .tr_valid(tr_valid1), .tr_ready(tr_ready), .tr_record(tr_record1),
        .stall_req(stall1), .level(level1), .inst_count(icnt1), .drop_count(drop1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit init_done = 1'b0;

    // Reference state: what the DUT must show in the current cycle.
    int              m_level = 0;
    int              m_drop  = 0;
    logic [31:0]     m_icnt  = '0;
    logic [31:0]     m_cyc   = '0;
    logic [TR_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] kind_of(input bit rw, input bit mr, input bit mw);
        if (rw && mw) return 3'd4;
        if (rw && mr) return 3'd2;
        if (rw)       return 3'd1;
        if (mw)       return 3'd3;
        return 3'd0;
    endfunction

    task automatic check_state();
        chk("level", 64'(level0), 64'(m_level));
        chk("tr_valid", 64'(tr_valid0), 64'(m_level != 0));
        chk("inst_count", 64'(icnt0), 64'(m_icnt));
        chk("drop_count", 64'(drop0), 64'(m_drop));
        chk("stall_off", 64'(stall0), 64'(0));
        chk("stall_on", 64'(stall1), 64'(m_level == DEPTH));
        chk("level_stall_inst", 64'(level1), 64'(m_level));
        if (m_level == 0) chk("idle_record_zero", 64'(tr_record0 == '0), 64'(1));
    endtask

    // Called just after a rising edge: checks state, drives one cycle, advances the model.
    task automatic step(input bit r, input bit en, input bit rv, input bit rdy,
                        input bit rw, input bit mr, input bit mw,
                        input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pc);
        logic [BASE_W-1:0] base;
        logic [TR_W-1:0]   rec;
        bit                pop, push;
        if (init_done) check_state();
        rst = r; enable = en; ret_valid = rv; tr_ready = rdy;
        ret_reg_write = rw; ret_mem_read = mr; ret_mem_write = mw;
        ret_rd = rd; ret_wdata = wd; ret_pc = pc;
        ret_instr = $urandom(); ret_mem_addr = $urandom(); ret_mem_data = $urandom();
        if (r) begin
            exp_q.delete();
            m_level = 0; m_icnt = '0; m_drop = 0; m_cyc = '0;
        end else begin
            pop  = (m_level != 0) && rdy;
            push = 1'b0;
            if (rv && en) begin
                if (m_level < DEPTH || pop) begin
                    base = {m_icnt, kind_of(rw, mr, mw), pc, ret_instr, rd, wd,
                            ret_mem_addr, ret_mem_data};
`ifdef TRACE_CYCLE_STAMP_EN
                    rec = {m_cyc, base};
`else
                    rec = base;
`endif
                    exp_q.push_back(rec);
                    push = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_icnt = m_icnt + 32'd1;
            end
            m_level = m_level + int'(push) - int'(pop);
            m_cyc   = m_cyc + 32'd1;
        end
        @(posedge clk);
        #1;
        init_done = 1'b1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Monitor: every accepted record must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (init_done && !rst && tr_valid0 && tr_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL record_unexpected actual=%0h required=none", tr_record0);
            end else if (tr_record0 !== exp_q[0]) begin
                n_fail++;
                $display("FAIL record actual=%0h required=%0h", tr_record0, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Single ADD retirement at PC 0.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h11, 32'h0);
        chk("add_valid", 64'(tr_valid0), 64'(1));
        chk("add_inst_count", 64'(icnt0), 64'(1));
        chk("add_kind", 64'(tr_record0[BASE_W-33 -: 3]), 64'(1));
        chk("add_rd", 64'(tr_record0[32*3+5-1 -: 5]), 64'(5));
        idle(1'b1);

        // All record kinds, drained as they arrive.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h1, 32'h100);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h2, 32'h104);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h3, 32'h108);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h4, 32'h10c);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h5, 32'h110);
        idle(1'b1);

        // Overflow: six retirements into four slots with no drain.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i), 32'(i), 32'(4 * i));
        chk("full_level", 64'(level0), 64'(DEPTH));
        chk("full_drops", 64'(drop0), 64'(2));
        chk("full_stall_off", 64'(stall0), 64'(0));
        chk("full_stall_on", 64'(stall1), 64'(1));
        // Retire while full and draining: accepted, level unchanged.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h200);
        chk("full_swap_level", 64'(level0), 64'(DEPTH));
        chk("full_swap_drops", 64'(drop0), 64'(2));
        // Enable low: no capture, drain continues.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h7, 32'h300);
        chk("disabled_inst_count", 64'(icnt0), 64'(7));

        // Reset mid-drain discards contents and the retirement in the reset cycle.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'(i), 32'h400);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h55, 32'h500);
        chk("rst_level", 64'(level0), 64'(0));
        chk("rst_inst_count", 64'(icnt0), 64'(0));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h600);
        chk("post_rst_inum", 64'(tr_record0[BASE_W-1 -: 32]), 64'(0));
        idle(1'b1);

`ifdef TRACE_CYCLE_STAMP_EN
        do_reset();
        for (int i = 0; i < 10; i++) idle(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h3, 32'h700);
        chk("cyc_stamp", 64'(tr_record0[TR_W-1 -: 32]), 64'(10));
        idle(1'b1);
`endif

        // Randomized traffic with occasional resets and disables.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 1'($urandom()), 1'($urandom()), 1'($urandom()),
                 5'($urandom()), $urandom(), $urandom());

        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        check_state();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
